// File: rtl/riscv_if_fetch.sv
// Instruction fetch stage: issues in-order word fetches, buffers returned parcels in a small
// queue and presents one registered instruction per cycle to pre-decode.
module riscv_if_fetch #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] PC_INIT     = 'h200,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_parcel_i,
  input  logic            imem_err_i,
  input  logic            pd_stall_i,
  input  logic            st_flush_i,
  input  logic [XLEN-1:0] st_nxt_pc_i,
  input  logic            bu_flush_i,
  input  logic [XLEN-1:0] bu_nxt_pc_i,
  input  logic            pd_latch_nxt_pc_i,
  input  logic [XLEN-1:0] pd_nxt_pc_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_insn_o,
  output logic            if_bubble_o,
  output logic            if_misaligned_o,
  output logic            if_access_fault_o
);

  localparam int unsigned     PW      = $clog2(QUEUE_DEPTH);
  localparam int unsigned     CW      = PW + 1;
  localparam int unsigned     SW      = CW + 2;
  localparam logic [31:0]     Nop     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PcReset = {PC_INIT[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d, count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            halted_q, halted_d, run_q;

  logic [XLEN-1:0]        q_pc_q   [QUEUE_DEPTH];
  logic [31:0]            q_insn_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_err_q, q_mis_q;

  logic            redir, redir_mis, issue, ack_ok, ack_drop, push, pop;
  logic [XLEN-1:0] redir_pc;
  logic [SW-1:0]   occupancy;

  assign redir = st_flush_i | bu_flush_i | pd_latch_nxt_pc_i;

  always_comb begin
    redir_pc = pd_nxt_pc_i;
    if (st_flush_i) begin
      redir_pc = st_nxt_pc_i;
    end else if (bu_flush_i) begin
      redir_pc = bu_nxt_pc_i;
    end
  end

  assign redir_mis = redir_pc[1:0] != 2'b00;

  // Queued entries plus everything still owed by memory must fit in the queue.
  assign occupancy  = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);
  assign imem_req_o = run_q & ~halted_q & (occupancy < SW'(QUEUE_DEPTH));
  assign imem_adr_o = fetch_pc_q;
  assign issue      = imem_req_o & imem_gnt_i;

  // Stale responses (older than the last redirect) always arrive before fresh ones.
  assign ack_drop = imem_ack_i & (discard_q != '0);
  assign ack_ok   = imem_ack_i & (discard_q == '0) & (inflight_q != '0);
  assign push     = ack_ok & ~redir;
  assign pop      = ~redir & ~pd_stall_i & (count_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    halted_d   = halted_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redir) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      inflight_d = '0;
      discard_d  = discard_q + inflight_q + CW'(issue) - CW'(ack_drop | ack_ok);
      halted_d   = redir_mis;
      rd_ptr_d   = '0;
      wr_ptr_d   = PW'(redir_mis);
      count_d    = CW'(redir_mis);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);
      if (push)  wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d   = rd_ptr_q + PW'(1);
      inflight_d = inflight_q + CW'(issue) - CW'(ack_ok);
      discard_d  = discard_q - CW'(ack_drop);
      halted_d   = halted_q | (push & imem_err_i);
      count_d    = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q             <= 1'b0;
      fetch_pc_q        <= PcReset;
      resp_pc_q         <= PcReset;
      inflight_q        <= '0;
      discard_q         <= '0;
      count_q           <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      halted_q          <= 1'b0;
      q_err_q           <= '0;
      q_mis_q           <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_insn_q[i] <= Nop;
      end
      if_pc_o           <= PcReset;
      if_insn_o         <= Nop;
      if_bubble_o       <= 1'b1;
      if_misaligned_o   <= 1'b0;
      if_access_fault_o <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      halted_q   <= halted_d;

      // A misaligned redirect leaves exactly one exception entry in slot 0.
      if (redir && redir_mis) begin
        q_pc_q[0]   <= redir_pc;
        q_insn_q[0] <= Nop;
        q_err_q[0]  <= 1'b0;
        q_mis_q[0]  <= 1'b1;
      end else if (push) begin
        q_pc_q[wr_ptr_q]   <= resp_pc_q;
        q_insn_q[wr_ptr_q] <= imem_parcel_i;
        q_err_q[wr_ptr_q]  <= imem_err_i;
        q_mis_q[wr_ptr_q]  <= 1'b0;
      end

      if (redir) begin
        if_bubble_o       <= 1'b1;
        if_misaligned_o   <= 1'b0;
        if_access_fault_o <= 1'b0;
      end else if (!pd_stall_i) begin
        if (pop) begin
          if_pc_o           <= q_pc_q[rd_ptr_q];
          if_insn_o         <= q_insn_q[rd_ptr_q];
          if_bubble_o       <= 1'b0;
          if_misaligned_o   <= q_mis_q[rd_ptr_q];
          if_access_fault_o <= q_err_q[rd_ptr_q];
        end else begin
          if_bubble_o       <= 1'b1;
          if_misaligned_o   <= 1'b0;
          if_access_fault_o <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(imem_ack_i && (inflight_q == '0) && (discard_q == '0)));
    end
  end

endmodule

// File: tb/tb_riscv_if_fetch.sv
// Bench for riscv_if_fetch: a queue-based reference model of the fetch stream checked every
// cycle, a table of redirect vectors, directed stall/fault/reset sequences and random traffic.
module tb_riscv_if_fetch;

  localparam int unsigned QD  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o, imem_gnt_i, imem_ack_i, imem_err_i;
  logic [31:0] imem_adr_o, imem_parcel_i;
  logic        pd_stall_i, st_flush_i, bu_flush_i, pd_latch_nxt_pc_i;
  logic [31:0] st_nxt_pc_i, bu_nxt_pc_i, pd_nxt_pc_i;
  logic [31:0] if_pc_o, if_insn_o;
  logic        if_bubble_o, if_misaligned_o, if_access_fault_o;

  always #5 clk_i = ~clk_i;

  riscv_if_fetch dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .imem_req_o        (imem_req_o),
    .imem_adr_o        (imem_adr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_ack_i        (imem_ack_i),
    .imem_parcel_i     (imem_parcel_i),
    .imem_err_i        (imem_err_i),
    .pd_stall_i        (pd_stall_i),
    .st_flush_i        (st_flush_i),
    .st_nxt_pc_i       (st_nxt_pc_i),
    .bu_flush_i        (bu_flush_i),
    .bu_nxt_pc_i       (bu_nxt_pc_i),
    .pd_latch_nxt_pc_i (pd_latch_nxt_pc_i),
    .pd_nxt_pc_i       (pd_nxt_pc_i),
    .if_pc_o           (if_pc_o),
    .if_insn_o         (if_insn_o),
    .if_bubble_o       (if_bubble_o),
    .if_misaligned_o   (if_misaligned_o),
    .if_access_fault_o (if_access_fault_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          cyc;
    logic        stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        err;
    logic        mis;
  } ent_t;

  typedef struct {
    logic        st;
    logic [31:0] st_pc;
    logic        bu;
    logic [31:0] bu_pc;
    logic        pd;
    logic [31:0] pd_pc;
    int          ack_hold;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int unsigned gnt_pct = 100, ack_pct = 100, err_permil = 0;
  logic [31:0] err_addr = 32'h1;

  // Reference model: requests owed by memory, accepted-but-unpresented entries, output slot.
  pend_t       pend[$];
  ent_t        mq[$];
  logic [31:0] m_fetch;
  logic        m_halt, m_run;
  logic [31:0] e_pc, e_insn;
  logic        e_ik, e_bub, e_mis, e_flt;

  vec_t vecs[9];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_fetch = 32'h200;
    m_halt  = 1'b0;
    m_run   = 1'b0;
    e_pc    = 32'h200;
    e_insn  = NOP;
    e_ik    = 1'b1;
    e_bub   = 1'b1;
    e_mis   = 1'b0;
    e_flt   = 1'b0;
  endtask

  task automatic clear_redirect();
    st_flush_i        = 1'b0;
    bu_flush_i        = 1'b0;
    pd_latch_nxt_pc_i = 1'b0;
  endtask

  // One clock cycle, entered and left just after the rising edge.
  task automatic step();
    pend_t       p;
    ent_t        e;
    logic        g, a, rd, exp_req, mis;
    logic [31:0] tgt;
    a = 1'b0;
    if (pend.size() > 0) a = (pend[0].cyc < cyc) && ($urandom_range(99) < ack_pct);
    imem_ack_i    = a;
    imem_parcel_i = $urandom;
    imem_err_i    = 1'b0;
    if (a) begin
      imem_parcel_i = pend[0].addr;
      imem_err_i    = (pend[0].addr == err_addr) || ($urandom_range(999) < err_permil);
    end
    g          = $urandom_range(99) < gnt_pct;
    imem_gnt_i = g;

    @(negedge clk_i);
    exp_req = m_run && !m_halt && (mq.size() + pend.size() < QD);
    chk1("imem_req", imem_req_o, exp_req);
    if (exp_req) chk32("imem_adr", imem_adr_o, m_fetch);
    chk32("if_pc", if_pc_o, e_pc);
    if (e_ik) chk32("if_insn", if_insn_o, e_insn);
    chk1("if_bubble", if_bubble_o, e_bub);
    chk1("if_misaligned", if_misaligned_o, e_mis);
    chk1("if_access_fault", if_access_fault_o, e_flt);

    rd  = st_flush_i | bu_flush_i | pd_latch_nxt_pc_i;
    tgt = st_flush_i ? st_nxt_pc_i : (bu_flush_i ? bu_nxt_pc_i : pd_nxt_pc_i);
    if (rd) begin
      e_bub = 1'b1;
      e_mis = 1'b0;
      e_flt = 1'b0;
    end else if (!pd_stall_i) begin
      if (mq.size() > 0) begin
        e      = mq.pop_front();
        e_pc   = e.pc;
        e_insn = e.insn;
        e_ik   = !e.mis;
        e_bub  = 1'b0;
        e_mis  = e.mis;
        e_flt  = e.err;
      end else begin
        e_bub = 1'b1;
        e_mis = 1'b0;
        e_flt = 1'b0;
      end
    end
    if (a) begin
      p = pend.pop_front();
      if (!p.stale && !rd) begin
        mq.push_back('{pc: p.addr, insn: p.addr, err: imem_err_i, mis: 1'b0});
        if (imem_err_i) m_halt = 1'b1;
      end
    end
    if (exp_req && g) begin
      pend.push_back('{addr: m_fetch, cyc: cyc, stale: 1'b0});
      m_fetch += 32'd4;
    end
    if (rd) begin
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      mq.delete();
      m_fetch = tgt;
      mis     = tgt[1:0] != 2'b00;
      m_halt  = mis;
      if (mis) mq.push_back('{pc: tgt, insn: NOP, err: 1'b0, mis: 1'b1});
    end
    m_run = 1'b1;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int max, input string name);
    int i;
    i = 0;
    while (if_bubble_o && i < max) begin
      step();
      i++;
    end
    chk1({name, "_valid_timeout"}, if_bubble_o, 1'b0);
  endtask

  initial begin
    logic        saw_drop, found;
    logic [31:0] t;
    int          n_valid;

    vecs[0] = '{1'b0, 32'h0,  1'b1, 32'h1000, 1'b0, 32'h0,   3, 32'h1000, 1'b0};
    vecs[1] = '{1'b1, 32'h80, 1'b0, 32'h0,    1'b1, 32'h400, 1, 32'h80,   1'b0};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 32'h1002, 1'b0, 32'h0,   2, 32'h1002, 1'b1};
    vecs[3] = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   0, 32'h100,  1'b0};
    vecs[4] = '{1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 32'h700, 2, 32'h300,  1'b0};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 32'h600,  1'b1, 32'h800, 0, 32'h600,  1'b0};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 32'h900, 4, 32'h900,  1'b0};
    vecs[7] = '{1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 32'hA01, 1, 32'hA01,  1'b1};
    vecs[8] = '{1'b1, 32'h40, 1'b0, 32'h0,    1'b0, 32'h0,   0, 32'h40,   1'b0};

    rst_ni        = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_ack_i    = 1'b0;
    imem_parcel_i = 32'h0;
    imem_err_i    = 1'b0;
    pd_stall_i    = 1'b0;
    st_nxt_pc_i   = 32'h0;
    bu_nxt_pc_i   = 32'h0;
    pd_nxt_pc_i   = 32'h0;
    clear_redirect();
    model_reset();

    @(negedge clk_i);
    chk1("rst_req", imem_req_o, 1'b0);
    chk32("rst_pc", if_pc_o, 32'h200);
    chk32("rst_insn", if_insn_o, NOP);
    chk1("rst_bubble", if_bubble_o, 1'b1);
    chk1("rst_mis", if_misaligned_o, 1'b0);
    chk1("rst_flt", if_access_fault_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Zero-wait memory streams consecutive words.
    wait_valid(10, "stream");
    for (int k = 0; k < 2; k++) begin
      chk32("stream_pc", if_pc_o, 32'h200 + 32'(4 * k));
      chk32("stream_insn", if_insn_o, 32'h200 + 32'(4 * k));
      chk1("stream_bubble", if_bubble_o, 1'b0);
      if (k == 0) step();
    end

    // Stall while memory keeps streaming: output holds, requests back off.
    pd_stall_i = 1'b1;
    saw_drop   = 1'b0;
    repeat (5) begin
      step();
      chk32("stall_hold_pc", if_pc_o, 32'h204);
      chk1("stall_hold_bubble", if_bubble_o, 1'b0);
      if (!imem_req_o) saw_drop = 1'b1;
    end
    chk1("stall_req_drop", saw_drop, 1'b1);
    pd_stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      wait_valid(5, "unstall");
      chk32("unstall_pc", if_pc_o, 32'h208 + 32'(4 * k));
    end

    for (int v = 0; v < 9; v++) begin
      gnt_pct = 100;
      ack_pct = 0;
      repeat (vecs[v].ack_hold) step();
      ack_pct           = 100;
      st_flush_i        = vecs[v].st;
      st_nxt_pc_i       = vecs[v].st_pc;
      bu_flush_i        = vecs[v].bu;
      bu_nxt_pc_i       = vecs[v].bu_pc;
      pd_latch_nxt_pc_i = vecs[v].pd;
      pd_nxt_pc_i       = vecs[v].pd_pc;
      step();
      clear_redirect();
      chk1("redir_bubble", if_bubble_o, 1'b1);
      wait_valid(20, "redir");
      chk32("redir_first_pc", if_pc_o, vecs[v].exp_pc);
      chk1("redir_first_mis", if_misaligned_o, vecs[v].exp_mis);
      if (vecs[v].exp_mis) begin
        repeat (4) begin
          step();
          chk1("halt_bubble", if_bubble_o, 1'b1);
          chk1("halt_no_req", imem_req_o, 1'b0);
        end
      end
    end

    // Access fault on the response for 0x20C.
    err_addr    = 32'h20C;
    st_flush_i  = 1'b1;
    st_nxt_pc_i = 32'h200;
    step();
    clear_redirect();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (!if_bubble_o && if_pc_o == 32'h20C) found = 1'b1;
    end
    chk1("fault_seen", found, 1'b1);
    chk1("fault_flag", if_access_fault_o, 1'b1);
    repeat (6) begin
      step();
      chk1("fault_no_req", imem_req_o, 1'b0);
    end
    err_addr = 32'h1;

    // Reset in the middle of a stream.
    st_flush_i  = 1'b1;
    st_nxt_pc_i = 32'h300;
    step();
    clear_redirect();
    repeat (6) step();
    rst_ni = 1'b0;
    #1;
    chk1("mid_rst_req", imem_req_o, 1'b0);
    chk32("mid_rst_pc", if_pc_o, 32'h200);
    chk32("mid_rst_insn", if_insn_o, NOP);
    chk1("mid_rst_bubble", if_bubble_o, 1'b1);
    chk1("mid_rst_mis", if_misaligned_o, 1'b0);
    chk1("mid_rst_flt", if_access_fault_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Random traffic against the model.
    err_permil = 20;
    n_valid    = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 20);
        ack_pct = $urandom_range(100, 20);
      end
      pd_stall_i = $urandom_range(99) < 30;
      if ($urandom_range(99) < 5) begin
        st_flush_i        = $urandom_range(99) < 40;
        bu_flush_i        = $urandom_range(99) < 40;
        pd_latch_nxt_pc_i = !(st_flush_i || bu_flush_i) || ($urandom_range(99) < 40);
        t = 32'($urandom_range(32'h3FFF)) << 2;
        if ($urandom_range(9) == 0) t[1:0] = 2'($urandom_range(3, 1));
        st_nxt_pc_i = t;
        bu_nxt_pc_i = t + 32'h40;
        pd_nxt_pc_i = t + 32'h80;
      end
      step();
      clear_redirect();
      if (!if_bubble_o) n_valid++;
    end
    chk1("random_progress", n_valid > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
